// File: rtl/input_debouncer_pkg.sv
// Shared defaults, filter-action encoding and sizing helpers for the input debouncer.
package input_debouncer_pkg;

    localparam int DEF_WIDTH      = 21;
    localparam int DEF_TICK_DIV   = 10000;
    localparam int DEF_STABLE_CNT = 4;

    typedef enum logic [1:0] {
        FILT_HOLD,
        FILT_CLEAR,
        FILT_COUNT,
        FILT_ACCEPT
    } filt_action_e;

    // Counter width for a modulus n; a single bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic filt_action_e filt_action(input logic tick,
                                                 input logic differs,
                                                 input logic at_limit);
        if (!tick)    return FILT_HOLD;
        if (!differs) return FILT_CLEAR;
        if (at_limit) return FILT_ACCEPT;
        return FILT_COUNT;
    endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: 2-FF synchronizer, tick-paced stability counter, debounced level
// and registered rise/fall pulses.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    logic          s1_q, s2_q;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    filt_action_e  act;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        act    = filt_action(tick, s2_q != dout_q, cnt_q == CNT_MAX);
        case (act)
            FILT_CLEAR:  cnt_d = '0;
            FILT_COUNT:  cnt_d = cnt_q + CW'(1);
            FILT_ACCEPT: begin
                cnt_d  = '0;
                dout_d = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so s2_q samples the old s1_q, giving a true two-stage synchronizer.
            s1_q   <= din;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw board inputs on a shared sample tick; produces clean levels,
// per-bit rise/fall pulses and a combined change strobe.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    // With TICK_DIV of 1 the counter is pinned at 0 and tick stays high.
    always_comb begin
        pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

    assign tick = (pcnt_q == PCNT_MAX);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .din  (din[i]),
            .dout (dout[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench: stimulus pushes expected change events, monitors pop and compare
// them whenever a debouncer reports a change.
module tb_input_debouncer;

    typedef struct {
        int         cyc;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din_a, dout_a, rise_a, fall_a;
    logic       changed_a, tick_a;
    logic [3:0] din_b, dout_b, rise_b, fall_b;
    logic       changed_b, tick_b;

    int   total = 0;
    int   bad   = 0;
    int   edge_idx = -1;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    input_debouncer #(.WIDTH(4), .TICK_DIV(4), .STABLE_CNT(3)) u_dut_a (
        .clk(clk), .reset(reset), .din(din_a), .dout(dout_a),
        .rise(rise_a), .fall(fall_a), .changed(changed_a), .tick(tick_a)
    );

    input_debouncer #(.WIDTH(4), .TICK_DIV(1), .STABLE_CNT(1)) u_dut_b (
        .clk(clk), .reset(reset), .din(din_b), .dout(dout_b),
        .rise(rise_b), .fall(fall_b), .changed(changed_b), .tick(tick_b)
    );

    // Index of the most recent clock edge since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_idx <= -1;
        else        edge_idx <= edge_idx + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_idx);
        end
    endtask

    task automatic wait_idx(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (edge_idx == n) return;
        end
        total++;
        bad++;
        $display("FAIL wait_idx: edge %0d never reached (now %0d)", n, edge_idx);
    endtask

    // Tick pattern: high for the edges 3, 7, 11, ... of build A; always high for build B.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("tick_a", tick_a, ((edge_idx + 1) % 4) == 3);
            check("tick_b", tick_b, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && (changed_a || (|rise_a) || (|fall_a))) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: rise=%b fall=%b changed=%b at edge %0d, none expected",
                         rise_a, fall_a, changed_a, edge_idx);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_event_edge", edge_idx, e.cyc);
                check("a_dout", dout_a, e.dout);
                check("a_rise", rise_a, e.rise);
                check("a_fall", fall_a, e.fall);
                check("a_changed", changed_a, 1'b1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && (changed_b || (|rise_b) || (|fall_b))) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: rise=%b fall=%b changed=%b at edge %0d, none expected",
                         rise_b, fall_b, changed_b, edge_idx);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_event_edge", edge_idx, e.cyc);
                check("b_dout", dout_b, e.dout);
                check("b_rise", rise_b, e.rise);
                check("b_fall", fall_b, e.fall);
                check("b_changed", changed_b, 1'b1);
            end
        end
    end

    initial begin
        reset = 1'b0;
        din_a = 4'hF;
        din_b = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_dout_a", dout_a, 4'h0);
        check("rst_pulses_a", {rise_a, fall_a, changed_a}, 9'h0);
        check("rst_dout_b", dout_b, 4'h0);
        reset = 1'b1;

        // Clean rise on bit 0: ticks 3, 7, 11 see it, accepted at edge 11.
        wait_idx(0);
        check("rel_dout_a", dout_a, 4'h0);
        check("rel_changed_a", changed_a, 1'b0);
        din_a = 4'b0001;
        qa.push_back('{cyc: 11, dout: 4'b0001, rise: 4'b0001, fall: 4'b0000});

        // Build B follows a step three edges later.
        wait_idx(4);
        din_b = 4'b0001;
        qb.push_back('{cyc: 7, dout: 4'b0001, rise: 4'b0001, fall: 4'b0000});

        wait_idx(10);
        check("a_before_accept", dout_a, 4'h0);

        // Bounce on bit 1: high for ticks 15, 19, low at 23, then high from 27.
        wait_idx(12);
        din_a = 4'b0011;
        wait_idx(19);
        din_a = 4'b0001;
        wait_idx(20);
        din_b = 4'b0000;
        qb.push_back('{cyc: 23, dout: 4'b0000, rise: 4'b0000, fall: 4'b0001});
        wait_idx(23);
        din_a = 4'b0011;
        qa.push_back('{cyc: 35, dout: 4'b0011, rise: 4'b0010, fall: 4'b0000});
        wait_idx(30);
        check("a_bounce_hold", dout_a, 4'b0001);

        // All high, then a two-bit fall on the same tick.
        wait_idx(35);
        din_a = 4'hF;
        qa.push_back('{cyc: 47, dout: 4'hF, rise: 4'b1100, fall: 4'b0000});
        wait_idx(47);
        din_a = 4'b0101;
        qa.push_back('{cyc: 59, dout: 4'b0101, rise: 4'b0000, fall: 4'b1010});

        // Reset mid-count on bit 2: progress from ticks 3 and 7 is discarded.
        wait_idx(60);
        din_a = 4'b0100;
        reset = 1'b0;
        #1;
        check("a_async_reset", dout_a, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        wait_idx(8);
        reset = 1'b0;
        #1;
        check("a_midcount_reset", dout_a, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        qa.push_back('{cyc: 11, dout: 4'b0100, rise: 4'b0100, fall: 4'b0000});
        wait_idx(10);
        check("a_restart_hold", dout_a, 4'h0);

        wait_idx(14);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        check("a_final_dout", dout_a, 4'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions the raw board inputs (5 push-buttons + 16 slide switches) before they reach the computer's PORTI/PORTJ, replacing the ad-hoc 100 Hz sampling register in the board top. Per bit it provides a 2-FF synchronizer, a tick-paced stability filter, a clean debounced level, and one-clock rise/fall pulses usable as interrupt sources. It sits directly upstream of the comp instance and runs on a single system clock.

Parameters:
WIDTH, 21, number of independent input bits (buttons in low bits, switches above)
TICK_DIV, 10000, clk cycles per sample tick (10000 at 1 MHz gives a 100 Hz tick); must be >= 1
STABLE_CNT, 4, consecutive ticks a new level must persist before acceptance; must be >= 1

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset)
din  input  WIDTH  raw asynchronous inputs
dout  output  WIDTH  debounced levels
rise  output  WIDTH  one-clk pulse per bit on accepted 0->1
fall  output  WIDTH  one-clk pulse per bit on accepted 1->0
changed  output  1  OR-reduce of rise|fall, same cycle
tick  output  1  sample strobe, high 1 clk every TICK_DIV clks

Behaviour:
- Reset (reset=0, asynchronous): sync stages, prescaler, per-bit counters, dout, rise, fall, changed all 0. No pulses on release even if din is high.
- Synchronizer: two flops per bit; s2 = din delayed 2 clks. Filter sees only s2.
- Prescaler pcnt: 0..TICK_DIV-1, increments every clk, wraps to 0. tick = (pcnt == TICK_DIV-1), combinational decode of pcnt. First tick is in clk cycle TICK_DIV-1 after reset release (cycle 0 = first edge after release). TICK_DIV=1: tick constantly high.
- Per-bit filter, evaluated only at edges where tick=1:
  - s2 == dout: cnt <= 0 (bounce discards progress).
  - s2 != dout and cnt == STABLE_CNT-1: dout <= s2, cnt <= 0, rise or fall asserted per direction.
  - s2 != dout otherwise: cnt <= cnt+1.
  - tick=0: cnt and dout hold.
- cnt width = clog2(STABLE_CNT) (min 1); never exceeds STABLE_CNT-1.
- rise/fall/changed registered: high exactly the one clk following the accepting tick edge, coincident with the new dout; 0 otherwise. A bit never pulses rise and fall together.
- Latency: step on din held steady -> dout updates at the STABLE_CNT-th tick edge whose sample includes the new s2 (>= 2 clks after din change). Max latency 2 + STABLE_CNT*TICK_DIV clks.
- Bits are fully independent; any subset may change on the same tick; rise/fall are vectors.
- Reset mid-count: all progress lost; debouncing restarts from dout=0.

Decomposition:
- Default TICK_DIV/STABLE_CNT values as `define constants in defs.v alongside the existing CPU/COMP defines.
- One sub-module, debounce_bit (sync flops, cnt, dout, rise/fall for one bit), instantiated WIDTH times via generate; the shared prescaler and changed OR-reduce stay in input_debouncer.

Test Plan (WIDTH=4, TICK_DIV=4, STABLE_CNT=3):
- Reset: hold reset=0 with din=4'hF, release -> dout=0, rise=fall=0, changed=0; tick first high in cycle 3, then cycles 7, 11, ...
- Clean rise: din[0] 0->1 at cycle 1, held -> dout[0]=1 after tick of cycle 11; rise=4'b0001 for one clk only; changed=1 same clk; fall=0.
- Bounce: din[1] high for 2 ticks then low for 1 tick, then high steadily -> no change during bounce; dout[1] rises only after 3 further consecutive high ticks; exactly one rise[1] pulse.
- Fall + multi-bit: from dout=4'hF, drive din=4'b0101 -> after 3 ticks dout=4'b0101, fall=4'b1010 in one clk, rise=0.
- Reset mid-count: din[2] high, assert reset after 2 ticks, release with din[2] still high -> dout[2] stays 0 until 3 full ticks after release, then one rise[2] pulse.
- TICK_DIV=1, STABLE_CNT=1 build: tick constant 1; din step -> dout follows 3 clks later with one-clk pulse.
